// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the fetch stage (I) and the
// memory stage (D). One access in flight at a time; when both stages want the
// port, the grant alternates so neither starves.
module mem_port_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic            clk,
    input  logic            rst,
    // fetch stage
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_ready,
    output logic [DW-1:0]   if_rdata,
    // memory stage
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_ready,
    output logic [DW-1:0]   d_rdata,
    // shared memory port
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic [DW-1:0]   mem_rdata,
    // pipeline control
    output logic            stall,
    output logic            busy
);

    localparam int BW = DW / 8;
    // WAIT lasts MEM_LAT-1 cycles: the counter is loaded with MEM_LAT-2 and
    // DONE follows the cycle it reads zero.
    localparam logic [3:0] WAIT_INIT = (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t          state, state_nxt;
    logic            last_d, last_d_nxt;   // most recent grant went to D
    logic            gnt_d, gnt_d_nxt;     // owner of the access in flight
    logic [3:0]      cnt, cnt_nxt;
    logic [AW-1:0]   addr_q, addr_nxt;
    logic            we_q, we_nxt;
    logic [DW-1:0]   wdata_q, wdata_nxt;
    logic [BW-1:0]   be_q, be_nxt;
    logic            grant, grant_d;

    // Next-state logic: arbitration in IDLE/DONE, latency sequencing otherwise.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_nxt  = state;
        last_d_nxt = last_d;
        gnt_d_nxt  = gnt_d;
        cnt_nxt    = cnt;
        addr_nxt   = addr_q;
        we_nxt     = we_q;
        wdata_nxt  = wdata_q;
        be_nxt     = be_q;
        grant      = 1'b0;
        grant_d    = 1'b0;

        unique case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    grant   = 1'b1;
                    // D wins a tie only if I was served last.
                    grant_d = d_req && (!if_req || !last_d);
                end
            end
            ISSUE: begin
                if (MEM_LAT == 1) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt   = WAIT_INIT;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_nxt = DONE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            DONE: begin
                // Hand the port straight to the other requester; never re-grant the owner.
                if (gnt_d ? if_req : d_req) begin
                    grant   = 1'b1;
                    grant_d = !gnt_d;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (grant) begin
            state_nxt  = ISSUE;
            gnt_d_nxt  = grant_d;
            last_d_nxt = grant_d;
            if (grant_d) begin
                addr_nxt  = d_addr;
                we_nxt    = d_we;
                wdata_nxt = d_wdata;
                be_nxt    = d_be;
            end else begin
                addr_nxt  = if_addr;
                we_nxt    = 1'b0;
                wdata_nxt = '0;
                be_nxt    = '1;
            end
        end
    end

    // State and payload registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state   <= IDLE;
            last_d  <= 1'b0;
            gnt_d   <= 1'b0;
            cnt     <= 4'd0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state   <= state_nxt;
            last_d  <= last_d_nxt;
            gnt_d   <= gnt_d_nxt;
            cnt     <= cnt_nxt;
            addr_q  <= addr_nxt;
            we_q    <= we_nxt;
            wdata_q <= wdata_nxt;
            be_q    <= be_nxt;
        end
    end

    assign mem_en    = (state == ISSUE);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;

    assign if_ready  = (state == DONE) && !gnt_d;
    assign d_ready   = (state == DONE) &&  gnt_d;
    assign if_rdata  = if_ready ? mem_rdata : '0;
    // A store's ready is only a write acknowledge, so it carries no data.
    assign d_rdata   = (d_ready && !we_q) ? mem_rdata : '0;

    assign stall     = (if_req && !if_ready) || (d_req && !d_ready);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level schedule model
// predicts every grant, issue and ready; a monitor compares the DUT each cycle.
module tb_mem_port_arbiter;

    localparam int L    = 2;
    localparam int MAXC = 8192;
    localparam int INF  = 1 << 30;

    logic        clk = 1'b0;
    logic        rst, if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_be;
    logic        if_ready, d_ready, mem_en, mem_we, stall, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LAT(L), .AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata),
        .stall(stall), .busy(busy)
    );

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          gap;    // idle cycles before req rises
        int          raise;
        int          dec;    // arbitration cycle
        int          rdy;
        bit          abort;  // killed by reset, no ready expected
    } txn_t;

    typedef struct {
        int          cyc;
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;

    // per-cycle stimulus and expectations
    bit          drv_rst[MAXC], drv_i[MAXC], drv_d[MAXC], drv_dwe[MAXC];
    logic [31:0] drv_ia[MAXC], drv_da[MAXC], drv_dwd[MAXC], mem_hist[MAXC];
    logic [3:0]  drv_dbe[MAXC];
    bit          exp_busy[MAXC], exp_ifr[MAXC], exp_dr[MAXC];
    int          dec_id[MAXC];

    txn_t txns[$];
    txn_t sc_i[$];
    txn_t sc_d[$];
    exp_t q_issue[$];
    exp_t q_ready[$];

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int sched_end = 0;
    bit last_d_m = 1'b0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, want);
        end
    endtask

    function automatic txn_t mk_fetch(input logic [31:0] a, input int gap);
        txn_t t = '{default: 0};
        t.addr = a; t.be = 4'hF; t.gap = gap;
        return t;
    endfunction

    function automatic txn_t mk_d(input bit we, input logic [31:0] a, input logic [31:0] wd,
                                  input logic [3:0] be, input int gap);
        txn_t t = '{default: 0};
        t.is_d = 1'b1; t.we = we; t.addr = a; t.wdata = wd; t.be = be; t.gap = gap;
        return t;
    endfunction

    // Lay a scheduled transaction into the per-cycle stimulus/expectation arrays.
    task automatic record(input txn_t t);
        dec_id[t.dec] = txns.size();
        txns.push_back(t);
        for (int c = t.raise; c <= t.rdy; c++) begin
            if (t.is_d) begin
                drv_d[c] = 1'b1; drv_dwe[c] = t.we; drv_da[c] = t.addr;
                drv_dwd[c] = t.wdata; drv_dbe[c] = t.be;
            end else begin
                drv_i[c] = 1'b1; drv_ia[c] = t.addr;
            end
        end
        for (int c = t.dec + 1; c <= t.rdy; c++) exp_busy[c] = 1'b1;
        if (!t.abort) begin
            if (t.is_d) exp_dr[t.rdy] = 1'b1;
            else        exp_ifr[t.rdy] = 1'b1;
        end
        if (t.rdy > sched_end) sched_end = t.rdy;
    endtask

    // Reference model: serve the sc_i/sc_d request lists on a port idle from 'start'.
    // Each access completes 1+L cycles after its grant; at completion the other side
    // is served if waiting, otherwise the port idles and ties go against last_d.
    task automatic schedule(input int start);
        int ii, di, i_prev, d_prev, i_rs, d_rs, c, r, free;
        bit in_done, owner_d, pick_d, got;
        txn_t t;
        ii = 0; di = 0; i_prev = start - 1; d_prev = start - 1;
        free = start; in_done = 1'b0; owner_d = 1'b0; r = 0;
        while (ii < sc_i.size() || di < sc_d.size()) begin
            i_rs = (ii < sc_i.size()) ? i_prev + 1 + sc_i[ii].gap : INF;
            d_rs = (di < sc_d.size()) ? d_prev + 1 + sc_d[di].gap : INF;
            got = 1'b0;
            pick_d = 1'b0;
            c = 0;
            if (in_done) begin
                if (owner_d && i_rs <= r) begin c = r; pick_d = 1'b0; got = 1'b1; end
                else if (!owner_d && d_rs <= r) begin c = r; pick_d = 1'b1; got = 1'b1; end
                else free = r + 1;
            end
            if (!got) begin
                c = (i_rs < d_rs) ? i_rs : d_rs;
                if (c < free) c = free;
                pick_d = (d_rs <= c) && ((i_rs > c) || !last_d_m);
            end
            if (pick_d) begin t = sc_d[di]; t.raise = d_rs; end
            else        begin t = sc_i[ii]; t.raise = i_rs; end
            t.dec = c;
            t.rdy = c + 1 + L;
            t.abort = 1'b0;
            record(t);
            if (pick_d) begin d_prev = t.rdy; di++; end
            else        begin i_prev = t.rdy; ii++; end
            last_d_m = pick_d;
            owner_d = pick_d;
            in_done = 1'b1;
            r = t.rdy;
        end
    endtask

    // Drive one cycle's inputs and post the expectations of any grant made in it.
    task automatic apply(input int c);
        exp_t e;
        txn_t t;
        rst = drv_rst[c]; if_req = drv_i[c]; if_addr = drv_ia[c];
        d_req = drv_d[c]; d_we = drv_dwe[c]; d_addr = drv_da[c];
        d_wdata = drv_dwd[c]; d_be = drv_dbe[c]; mem_rdata = mem_hist[c];
        if (dec_id[c] >= 0) begin
            t = txns[dec_id[c]];
            e.cyc = t.dec + 1; e.is_d = t.is_d; e.we = t.we; e.addr = t.addr;
            e.wdata = t.wdata; e.be = t.be; e.data = '0;
            q_issue.push_back(e);
            if (!t.abort) begin
                e.cyc = t.rdy;
                e.data = (t.is_d && t.we) ? 32'h0 : mem_hist[t.rdy];
                q_ready.push_back(e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        apply(cyc);
    endtask

    // Monitor: compare outputs mid-cycle against the scoreboard queues and arrays.
    initial begin
        exp_t e;
        logic [31:0] rd;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (drv_rst[cyc-1]) begin
                    check("post_rst_mem_en", mem_en, 0);
                    check("post_rst_mem_we", mem_we, 0);
                    check("post_rst_if_ready", if_ready, 0);
                    check("post_rst_d_ready", d_ready, 0);
                    check("post_rst_busy", busy, 0);
                end
                check("busy", busy, exp_busy[cyc]);
                check("stall", stall, (drv_i[cyc] && !exp_ifr[cyc]) || (drv_d[cyc] && !exp_dr[cyc]));
                if (!if_ready) check("if_rdata_idle", if_rdata, 0);
                if (!d_ready)  check("d_rdata_idle", d_rdata, 0);
                if (mem_en) begin
                    if (q_issue.size() == 0) begin
                        check("unexpected_mem_en", mem_en, 0);
                    end else begin
                        e = q_issue.pop_front();
                        check("issue_cycle", cyc, e.cyc);
                        check("issue_addr", mem_addr, e.addr);
                        check("issue_we", mem_we, e.we);
                        check("issue_be", mem_be, e.be);
                        if (e.we) check("issue_wdata", mem_wdata, e.wdata);
                    end
                end
                if (if_ready || d_ready) begin
                    check("ready_exclusive", if_ready && d_ready, 0);
                    if (q_ready.size() == 0) begin
                        check("unexpected_ready", {if_ready, d_ready}, 0);
                    end else begin
                        e = q_ready.pop_front();
                        rd = e.is_d ? d_rdata : if_rdata;
                        check("ready_cycle", cyc, e.cyc);
                        check("ready_port_d", d_ready, e.is_d);
                        check("ready_data", rd, e.data);
                    end
                end
            end
        end
    end

    initial begin
        int s, ni, nd;
        txn_t t;
        for (int c = 0; c < MAXC; c++) begin
            dec_id[c] = -1;
            mem_hist[c] = $urandom;
        end

        // Reset for two cycles with random requests on the inputs.
        for (int c = 0; c < 2; c++) begin
            drv_rst[c] = 1'b1;
            drv_i[c] = 1'($urandom); drv_ia[c] = $urandom;
            drv_d[c] = 1'($urandom); drv_dwe[c] = 1'($urandom);
            drv_da[c] = $urandom; drv_dwd[c] = $urandom; drv_dbe[c] = 4'($urandom);
        end

        // Single fetch.
        s = 3;
        sc_i = '{mk_fetch(32'h40, 0)}; sc_d = '{};
        schedule(s);
        mem_hist[s + 3] = 32'h24020005;

        // Simultaneous store and fetch.
        s = sched_end + 2;
        sc_i = '{mk_fetch(32'h44, 0)};
        sc_d = '{mk_d(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 0)};
        schedule(s);

        // Fairness with both sides continuously requesting.
        s = sched_end + 2;
        sc_i = '{mk_fetch(32'h48, 0), mk_fetch(32'h4C, 0)};
        sc_d = '{mk_d(1'b0, 32'h200, 32'h0, 4'hF, 0), mk_d(1'b1, 32'h204, 32'h12345678, 4'h3, 0)};
        schedule(s);

        // Partial store.
        s = sched_end + 2;
        sc_i = '{};
        sc_d = '{mk_d(1'b1, 32'h300, 32'h0000AB00, 4'b0010, 0)};
        schedule(s);

        // Reset in the middle of a fetch; the held request is served afresh.
        s = sched_end + 2;
        t = mk_fetch(32'h80, 0);
        t.raise = s; t.dec = s; t.rdy = s + 2; t.abort = 1'b1;
        record(t);
        drv_rst[s + 2] = 1'b1;
        last_d_m = 1'b0;
        sc_i = '{mk_fetch(32'h80, 0)}; sc_d = '{};
        schedule(s + 3);

        // Random traffic.
        for (int k = 0; k < 60 && sched_end < MAXC - 200; k++) begin
            sc_i = '{}; sc_d = '{};
            ni = $urandom_range(0, 3);
            nd = $urandom_range(0, 3);
            if (ni + nd == 0) ni = 1;
            for (int j = 0; j < ni; j++) sc_i.push_back(mk_fetch($urandom, $urandom_range(0, 3)));
            for (int j = 0; j < nd; j++)
                sc_d.push_back(mk_d(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom_range(0, 3)));
            schedule(sched_end + 1 + $urandom_range(1, 3));
        end

        apply(0);
        step();
        mon_en = 1'b1;
        while (cyc < sched_end + 4) step();
        @(negedge clk);
        #1;
        check("issue_queue_drained", q_issue.size(), 0);
        check("ready_queue_drained", q_ready.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, meaning cycles from the cycle mem_en is high to the cycle mem_rdata is valid; legal range 1..15.
REQ-002 SHALL have parameter AW, default 32, meaning address width.
REQ-003 SHALL have parameter DW, default 32, meaning data width; byte-enable width is DW/8.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports if_req  in  1 and if_addr  in  AW, carrying the fetch-stage read request and its word address.
REQ-007 SHALL have ports if_ready  out  1 and if_rdata  out  DW, carrying the fetch completion pulse and the instruction word.
REQ-008 SHALL have ports d_req  in  1, d_we  in  1, d_addr  in  AW, d_wdata  in  DW and d_be  in  DW/8, carrying the memory-stage request (d_we: 1=store, 0=load), address, store data and byte enables.
REQ-009 SHALL have ports d_ready  out  1 and d_rdata  out  DW, carrying the memory-stage completion pulse and the load data.
REQ-010 SHALL have ports mem_en  out  1, mem_we  out  1, mem_addr  out  AW, mem_wdata  out  DW and mem_be  out  DW/8, forming the single shared memory port.
REQ-011 SHALL have port mem_rdata  in  DW, carrying memory read data.
REQ-012 SHALL have port stall  out  1, the pipeline freeze request.
REQ-013 SHALL have port busy  out  1, high whenever the state is not IDLE.

Function
REQ-014 SHALL implement an FSM with states IDLE, ISSUE, WAIT and DONE, allowing at most one outstanding access.
REQ-015 SHALL treat requests as level-held: the requester holds req and its payload stable up to and including its ready cycle.
REQ-016 SHALL grant as follows when in IDLE with any req high: if only one req is high, grant it; if both are high, grant D when last_d=0 and I when last_d=1; then go to ISSUE and register the granted payload.
REQ-017 SHALL set last_d=1 on a D grant and last_d=0 on an I grant; last_d is 0 after reset.
REQ-018 SHALL, in ISSUE, drive mem_en=1 for exactly one cycle with the registered mem_addr, mem_we, mem_wdata and mem_be (mem_we=0 and mem_be all-ones for fetches).
REQ-019 SHALL spend MEM_LAT-1 cycles in WAIT (none when MEM_LAT=1), counted by a 4-bit down-counter, and then enter DONE.
REQ-020 SHALL, in DONE, pulse the granted requester's ready for exactly one cycle, with its rdata equal to mem_rdata in that same cycle; a store's ready acts as the write acknowledge and its d_rdata is 0.
REQ-021 SHALL, in DONE, go directly to ISSUE with a new grant if the other requester's req is high, and otherwise return to IDLE; the same requester is never re-granted from DONE.
REQ-022 SHALL make the latency from a request seen in IDLE to its ready equal to 1+MEM_LAT cycles; a back-to-back grant from DONE has mem_en in the next cycle.
REQ-023 SHALL drive mem_en, if_ready and d_ready to 0 in every state where REQ-018 and REQ-020 do not assert them, and drive if_rdata and d_rdata to 0 when not ready.
REQ-024 SHALL compute stall = (if_req & ~if_ready) | (d_req & ~d_ready), combinationally.
REQ-025 SHALL, if a requester drops req before its ready (protocol violation), still complete the access and pulse ready; the memory transaction is never aborted.
REQ-026 SHALL ignore any req raised while in ISSUE or WAIT until the next arbitration point (DONE or IDLE).

Reset
REQ-027 SHALL, while rst=1 at a clock edge, set state IDLE, last_d=0, counter 0 and all registered payload to 0; mem_en, mem_we, if_ready, d_ready and busy read 0 in the following cycle.
REQ-028 SHALL, on reset asserted mid-access, discard the in-flight response: no ready pulse is emitted and late mem_rdata is ignored.
REQ-029 SHALL, after rst falls, re-serve any still-held request from scratch, starting with IDLE arbitration.

Verification (MEM_LAT=2, cycle 0 = first cycle a request is seen)
REQ-030 SHALL cover reset: rst high for 2 cycles with random inputs -> mem_en=0, ready outputs=0 and busy=0 from the cycle after the first rst edge.
REQ-031 SHALL cover a single fetch: if_req with if_addr=0x40 in cycle 0 -> mem_en=1, mem_we=0, mem_addr=0x40 in cycle 1; mem_rdata=0x24020005 in cycle 3 -> if_ready=1, if_rdata=0x24020005 in cycle 3; stall=1 in cycles 0-2.
REQ-032 SHALL cover a simultaneous fetch and store with last_d=0: d store to 0x100, wdata 0xDEADBEEF, be 0xF, plus fetch to 0x44 -> D issued in cycle 1 with mem_we=1 and d_ready in cycle 3; I issued in cycle 4 with if_ready in cycle 6.
REQ-033 SHALL cover fairness: d_req and if_req held continuously with new payloads after each ready -> grant order D,I,D,I with mem_en in cycles 1,4,7,10.
REQ-034 SHALL cover a partial store: d_we=1, d_be=0b0010, d_wdata=0x0000AB00 -> mem_be=0b0010 and mem_wdata=0x0000AB00 in the ISSUE cycle.
REQ-035 SHALL cover reset mid-access: fetch in cycle 0 and rst=1 during cycle 2 -> no if_ready in cycle 3; after rst falls with if_req still held, mem_en is seen 2 cycles later.
